// File: rtl/game_pkg.sv
// Shared state encoding, widths and miss popcount for the game-flow sequencer.
// Pure definitions; no timing or flow control of its own.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int LIVES_W = 4;
  localparam int PC_W    = 6;
  localparam int MISS_MAX = 32;

  function automatic logic [PC_W-1:0] popcount(input logic [MISS_MAX-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MISS_MAX; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_hold_counter.sv
// Result-screen lockout: counts while enabled, saturates at HOLD_CYC-1, done is registered.
// done rises in the same cycle the count reaches HOLD_CYC-1; clear wins over enable.
module hold_counter #(
  parameter int HOLD_CYC = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] MAX = CW'(HOLD_CYC - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;

  always_comb begin
    nxt = (cnt == MAX) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      cnt  <= nxt;
      done <= (nxt == MAX);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Rhythm-game flow sequencer: IDLE/WAIT/RUN/PAUSE/STOP, solver and music control, lives budget.
// All outputs registered; decisions take effect the cycle after the triggering input.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int LIVES    = 3,
  parameter int HOLD_CYC = 100000000,
  parameter int PW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key,
  input  logic               abort,
  input  logic               pause_tog,
  input  logic               ready,
  input  logic               endpass,
  input  logic [LANES-1:0]   miss,
  input  logic               keep,
  input  logic [PW-1:0]      perc,
  output logic [2:0]         state,
  output logic               prepare,
  output logic               start,
  output logic               halt,
  output logic               mus_start,
  output logic               mus_end,
  output logic               mus_wrong,
  output logic [LIVES_W-1:0] lives_left,
  output logic               wa,
  output logic [PW-1:0]      saved_perc,
  output logic               result_ok
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  state_t            st;
  logic              played;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   lives_ext;
  logic [PC_W-1:0]   lives_rem;
  logic              lethal;
  logic              hit;
  logic              hold_clear;

  assign state = st;

  always_comb begin
    pc        = popcount(MISS_MAX'(miss));
    lives_ext = PC_W'(lives_left);
    lives_rem = lives_ext - pc;
    // pc >= lives is the non-underflowing form of (lives - pc) <= 0
    lethal    = !keep && (pc >= lives_ext);
    hit       = !keep && (pc != '0);
  end

  // Counter is held clear outside STOP and on the accepted exit key, so
  // result_ok never lingers into IDLE.
  assign hold_clear = (st != ST_STOP) || (key && result_ok);

  hold_counter #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clear (hold_clear),
    .en    (st == ST_STOP),
    .done  (result_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      played     <= 1'b0;
      prepare    <= 1'b0;
      start      <= 1'b0;
      halt       <= 1'b0;
      mus_start  <= 1'b0;
      mus_end    <= 1'b1;
      mus_wrong  <= 1'b0;
      lives_left <= LIVES_INIT;
      wa         <= 1'b0;
      saved_perc <= '0;
    end else begin
      start     <= 1'b0;
      mus_start <= 1'b0;
      case (st)
        ST_IDLE: begin
          mus_end    <= 1'b1;
          wa         <= 1'b0;
          mus_wrong  <= 1'b0;
          lives_left <= LIVES_INIT;
          if (key || played) begin
            st      <= ST_WAIT;
            prepare <= 1'b1;
            halt    <= 1'b0;
            played  <= 1'b1;
            mus_end <= 1'b0;
          end
        end

        ST_WAIT: begin
          mus_end <= 1'b0;
          if (ready && key) begin
            st        <= ST_RUN;
            prepare   <= 1'b0;
            start     <= 1'b1;
            mus_start <= 1'b1;
          end
        end

        ST_RUN: begin
          if (endpass) begin
            st   <= ST_STOP;
            halt <= 1'b1;
          end else if (abort) begin
            st      <= ST_IDLE;
            halt    <= 1'b1;
            mus_end <= 1'b1;
          end else if (lethal) begin
            st         <= ST_STOP;
            halt       <= 1'b1;
            wa         <= 1'b1;
            mus_wrong  <= 1'b1;
            mus_end    <= 1'b1;
            saved_perc <= perc;
            lives_left <= '0;
          end else begin
            // A survivable miss and a pause request in the same cycle both take effect.
            if (hit) begin
              lives_left <= lives_rem[LIVES_W-1:0];
            end
            if (pause_tog) begin
              st      <= ST_PAUSE;
              halt    <= 1'b1;
              mus_end <= 1'b1;
            end
          end
        end

        ST_PAUSE: begin
          if (abort) begin
            st      <= ST_IDLE;
            halt    <= 1'b1;
            mus_end <= 1'b1;
          end else if (pause_tog) begin
            st        <= ST_RUN;
            halt      <= 1'b0;
            mus_end   <= 1'b0;
            mus_start <= 1'b1;
          end
        end

        ST_STOP: begin
          if (key && result_ok) begin
            st         <= ST_IDLE;
            mus_end    <= 1'b1;
            wa         <= 1'b0;
            mus_wrong  <= 1'b0;
            lives_left <= LIVES_INIT;
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; expectations queued per step and checked one cycle later.
module tb_game_flow_ctrl;

  localparam int F_STATE = 0, F_PREP = 1, F_START = 2, F_HALT = 3, F_MSTART = 4, F_MEND = 5;
  localparam int F_MWRONG = 6, F_LIVES = 7, F_WA = 8, F_SPERC = 9, F_ROK = 10;
  localparam int S_IDLE = 0, S_WAIT = 1, S_RUN = 2, S_PAUSE = 3, S_STOP = 4;

  logic        clk = 1'b0;
  logic        rst, key, abort, pause_tog, ready, endpass, keep;
  logic [3:0]  miss;
  logic [15:0] perc;
  logic [2:0]  state;
  logic        prepare, start, halt, mus_start, mus_end, mus_wrong, wa, result_ok;
  logic [3:0]  lives_left;
  logic [15:0] saved_perc;

  typedef struct {
    string       tag;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  game_flow_ctrl #(.LANES(4), .LIVES(3), .HOLD_CYC(10), .PW(16)) dut (
    .clk(clk), .rst(rst), .key(key), .abort(abort), .pause_tog(pause_tog),
    .ready(ready), .endpass(endpass), .miss(miss), .keep(keep), .perc(perc),
    .state(state), .prepare(prepare), .start(start), .halt(halt),
    .mus_start(mus_start), .mus_end(mus_end), .mus_wrong(mus_wrong),
    .lives_left(lives_left), .wa(wa), .saved_perc(saved_perc), .result_ok(result_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(int f);
    case (f)
      F_STATE:  return 32'(state);
      F_PREP:   return 32'(prepare);
      F_START:  return 32'(start);
      F_HALT:   return 32'(halt);
      F_MSTART: return 32'(mus_start);
      F_MEND:   return 32'(mus_end);
      F_MWRONG: return 32'(mus_wrong);
      F_LIVES:  return 32'(lives_left);
      F_WA:     return 32'(wa);
      F_SPERC:  return 32'(saved_perc);
      F_ROK:    return 32'(result_ok);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic exp(input string tag, input int fld, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.fld = fld;
    e.val = val;
    q.push_back(e);
  endtask

  // Advance one clock, then compare everything queued for this cycle.
  task automatic step();
    exp_t e;
    logic [31:0] o;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.fld);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: got %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1; key = 1'b0; abort = 1'b0; pause_tog = 1'b0; ready = 1'b0;
    endpass = 1'b0; keep = 1'b0; miss = 4'b0; perc = 16'd0;

    // Reset values
    exp("rst_state", F_STATE, S_IDLE); exp("rst_prep", F_PREP, 0); exp("rst_start", F_START, 0);
    exp("rst_halt", F_HALT, 0); exp("rst_mstart", F_MSTART, 0); exp("rst_mend", F_MEND, 1);
    exp("rst_mwrong", F_MWRONG, 0); exp("rst_lives", F_LIVES, 3); exp("rst_wa", F_WA, 0);
    exp("rst_sperc", F_SPERC, 0); exp("rst_rok", F_ROK, 0);
    step();
    key = 1'b1;
    exp("rst_over_key", F_STATE, S_IDLE);
    step();
    rst = 1'b0; key = 1'b0;
    exp("idle_hold", F_STATE, S_IDLE);
    step();

    // Scenario 1: IDLE -> WAIT -> RUN
    key = 1'b1;
    exp("s1_wait", F_STATE, S_WAIT); exp("s1_prep", F_PREP, 1); exp("s1_mend", F_MEND, 0);
    step();
    exp("s1_noready", F_STATE, S_WAIT); exp("s1_noready_start", F_START, 0);
    step();
    ready = 1'b1;
    exp("s1_run", F_STATE, S_RUN); exp("s1_start", F_START, 1); exp("s1_mstart", F_MSTART, 1);
    exp("s1_prep0", F_PREP, 0);
    step();
    key = 1'b0; ready = 1'b0;
    exp("s1_start_end", F_START, 0); exp("s1_mstart_end", F_MSTART, 0); exp("s1_lives", F_LIVES, 3);
    step();

    // Scenario 2: two misses then lethal third
    perc = 16'd100; miss = 4'b0011;
    exp("s2_lives1", F_LIVES, 1); exp("s2_run", F_STATE, S_RUN);
    step();
    perc = 16'd555; miss = 4'b0100;
    exp("s2_stop", F_STATE, S_STOP); exp("s2_lives0", F_LIVES, 0); exp("s2_wa", F_WA, 1);
    exp("s2_sperc", F_SPERC, 555); exp("s2_mwrong", F_MWRONG, 1); exp("s2_mend", F_MEND, 1);
    exp("s2_halt", F_HALT, 1); exp("s2_rok0", F_ROK, 0);
    step();
    miss = 4'b0; perc = 16'd777;
    exp("s2_sperc_frozen", F_SPERC, 555);
    step();

    // Scenario 6: lockout in STOP (now at STOP cycle 1)
    for (int c = 2; c <= 5; c++) begin
      if (c == 4) exp("s6_rok_c4", F_ROK, 0);
      step();
    end
    key = 1'b1;
    exp("s6_early_key", F_STATE, S_STOP); exp("s6_rok_c6", F_ROK, 0);
    step();
    key = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      if (c == 8) exp("s6_rok_c8", F_ROK, 0);
      step();
    end
    exp("s6_rok_c9", F_ROK, 1); exp("s6_still_stop", F_STATE, S_STOP);
    step();
    key = 1'b1;
    exp("s6_idle", F_STATE, S_IDLE); exp("s6_rok_clr", F_ROK, 0); exp("s6_wa0", F_WA, 0);
    exp("s6_lives", F_LIVES, 3); exp("s6_mend", F_MEND, 1); exp("s6_mwrong0", F_MWRONG, 0);
    step();
    key = 1'b0;
    exp("s6_auto_wait", F_STATE, S_WAIT); exp("s6_prep", F_PREP, 1);
    step();

    // Scenario 3: invincible mode
    key = 1'b1; ready = 1'b1;
    exp("s3_run", F_STATE, S_RUN);
    step();
    key = 1'b0; ready = 1'b0; keep = 1'b1; miss = 4'b0011;
    exp("s3_lives_a", F_LIVES, 3); exp("s3_run_a", F_STATE, S_RUN);
    step();
    miss = 4'b0100;
    exp("s3_lives_b", F_LIVES, 3); exp("s3_run_b", F_STATE, S_RUN);
    step();
    miss = 4'b1111;
    exp("s3_lives_c", F_LIVES, 3); exp("s3_run_c", F_STATE, S_RUN);
    step();
    keep = 1'b0; miss = 4'b0;

    // Scenario 5: pause
    pause_tog = 1'b1;
    exp("s5_pause", F_STATE, S_PAUSE); exp("s5_halt", F_HALT, 1); exp("s5_mend", F_MEND, 1);
    step();
    pause_tog = 1'b0; miss = 4'b1111; endpass = 1'b1;
    exp("s5_paused", F_STATE, S_PAUSE); exp("s5_lives", F_LIVES, 3);
    step();
    miss = 4'b0; endpass = 1'b0; pause_tog = 1'b1;
    exp("s5_resume", F_STATE, S_RUN); exp("s5_halt0", F_HALT, 0); exp("s5_mend0", F_MEND, 0);
    exp("s5_mstart", F_MSTART, 1);
    step();
    pause_tog = 1'b0;
    exp("s5_mstart_end", F_MSTART, 0);
    step();
    miss = 4'b1000;
    exp("single_miss", F_LIVES, 2);
    step();
    miss = 4'b0;

    // Scenario 4: endpass beats a lethal miss
    endpass = 1'b1; miss = 4'b1111;
    exp("s4_stop", F_STATE, S_STOP); exp("s4_wa0", F_WA, 0); exp("s4_lives", F_LIVES, 2);
    exp("s4_halt", F_HALT, 1); exp("s4_mwrong0", F_MWRONG, 0);
    step();
    endpass = 1'b0; miss = 4'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) exp("s4_rok_c8", F_ROK, 0);
      step();
    end
    exp("s4_rok_c9", F_ROK, 1);
    step();
    key = 1'b1;
    exp("s4_idle", F_STATE, S_IDLE);
    step();
    key = 1'b0;
    exp("s4_wait", F_STATE, S_WAIT);
    step();

    // Abort from RUN, then reset mid-game
    key = 1'b1; ready = 1'b1;
    exp("ab_run", F_STATE, S_RUN);
    step();
    key = 1'b0; ready = 1'b0; abort = 1'b1;
    exp("ab_idle", F_STATE, S_IDLE); exp("ab_halt", F_HALT, 1); exp("ab_mend", F_MEND, 1);
    step();
    abort = 1'b0;
    exp("ab_auto_wait", F_STATE, S_WAIT);
    step();
    rst = 1'b1;
    exp("mid_rst_idle", F_STATE, S_IDLE); exp("mid_rst_prep", F_PREP, 0);
    step();
    rst = 1'b0;
    exp("mid_rst_no_auto", F_STATE, S_IDLE);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
